// File: rtl/data_mem_alt_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_alt_pkg
// Shared constants and types for the data_mem_alt scratch/frame-line store.
//   DATA_WIDTH_DEFAULT : default word width in bits
//   ADDR_WIDTH_DEFAULT : default address width in bits
//   depth_of()         : number of words addressable by a given address width
//   word_t             : one memory word at the default width
// -----------------------------------------------------------------------------
package data_mem_alt_pkg;

    localparam int DATA_WIDTH_DEFAULT = 8;
    localparam int ADDR_WIDTH_DEFAULT = 8;

    // Full binary decode: every address pattern maps to a real word.
    function automatic int depth_of(input int addr_width);
        return 1 << addr_width;
    endfunction

    typedef logic [DATA_WIDTH_DEFAULT-1:0] word_t;

endpackage : data_mem_alt_pkg

// File: rtl/data_mem_alt.sv
// -----------------------------------------------------------------------------
// data_mem_alt
// Simple dual-port register-file memory: one write port, one registered read
// port, single clock. Contents, read data and read-valid are cleared by a
// synchronous active-high reset, which overrides both ports.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   synchronous active-high reset
//   wr_en    in   write enable
//   rd_en    in   read enable
//   wr_addr  in   [ADDR_WIDTH-1:0] write address
//   rd_addr  in   [ADDR_WIDTH-1:0] read address
//   wr_data  in   [DATA_WIDTH-1:0] write data
//   rd_data  out  [DATA_WIDTH-1:0] registered read data
//   rd_valid out  high for the cycle after an accepted read
//
// Configuration macro:
//   DATA_MEM_ALT_WR_BYPASS_EN - when defined, a read and a write to the same
//   address in the same cycle return wr_data (write-first). When undefined the
//   stored (old) word is returned (read-first).
// -----------------------------------------------------------------------------
module data_mem_alt
    import data_mem_alt_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid
);

    localparam int DEPTH = depth_of(ADDR_WIDTH);

    // Port semantics: there is no backpressure. A read is accepted on every
    // rising edge where rd_en=1 and reset=0; rd_data is updated on that edge
    // and rd_valid is high for exactly the following cycle. With rd_en=0,
    // rd_data holds and rd_valid drops. Writes are accepted likewise on wr_en.

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;

    // Write port: next array image.
    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    // Read port: samples the pre-write array, so a same-address collision is
    // read-first unless forwarding is compiled in.
    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (rd_en) begin
            rd_data_d  = mem_q[rd_addr];
            rd_valid_d = 1'b1;
`ifdef DATA_MEM_ALT_WR_BYPASS_EN
            if (wr_en && (wr_addr == rd_addr)) begin
                rd_data_d = wr_data;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q      <= '{default: '0};
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule : data_mem_alt

// File: tb/tb_data_mem_alt.sv
// -----------------------------------------------------------------------------
// tb_data_mem_alt
// Directed testbench for data_mem_alt at DATA_WIDTH=16, ADDR_WIDTH=3.
// Each step drives one cycle of inputs, pushes the hand-computed rd_data for
// that cycle into exp_q, clocks, then pops and compares rd_data and rd_valid.
// -----------------------------------------------------------------------------
module tb_data_mem_alt;

    localparam int DW = 16;
    localparam int AW = 3;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic          rd_en;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data;
    logic          rd_valid;

    always #5 clk = ~clk;

    data_mem_alt #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .rd_en   (rd_en),
        .wr_addr (wr_addr),
        .rd_addr (rd_addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .rd_valid(rd_valid)
    );

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    int            checks   = 0;
    int            failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    // One clock of stimulus; outputs are sampled 1 time unit after the edge.
    task automatic step(input string tag,
                        input logic rst, input logic we, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra,
                        input logic [DW-1:0] exp_data, input logic exp_valid);
        logic [DW-1:0] e;
        reset   = rst;
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        rd_en   = re;
        rd_addr = ra;
        exp_q.push_back(exp_data);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_eq({tag, "_data"}, 32'(rd_data), 32'(e));
        check_eq({tag, "_valid"}, 32'(rd_valid), 32'(exp_valid));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    localparam logic [DW-1:0] COLLIDE_EXP =
`ifdef DATA_MEM_ALT_WR_BYPASS_EN
        16'h2222;
`else
        16'h1111;
`endif

    initial begin
        reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_data = '0;
        @(posedge clk);
        #1;

        //      tag         rst   we    wa    wd        re    ra    exp_data  exp_v
        step("rst0",       1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0);
        // Preload mem[1], confirm it, then reset must wipe it.
        step("pre_wr",     1'b0, 1'b1, 3'd1, 16'h0001, 1'b0, 3'd0, 16'h0000, 1'b0);
        step("pre_rd",     1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd1, 16'h0001, 1'b1);
        step("rst1",       1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd1, 16'h0000, 1'b0);
        step("rst_rd1",    1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd1, 16'h0000, 1'b1);
        // Write then read back-to-back.
        step("wr2",        1'b0, 1'b1, 3'd2, 16'h0002, 1'b0, 3'd0, 16'h0000, 1'b0);
        step("wr3",        1'b0, 1'b1, 3'd3, 16'h0003, 1'b0, 3'd0, 16'h0000, 1'b0);
        step("wr4",        1'b0, 1'b1, 3'd4, 16'h0004, 1'b0, 3'd0, 16'h0000, 1'b0);
        step("rd2",        1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 16'h0002, 1'b1);
        step("rd3",        1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 16'h0003, 1'b1);
        step("rd4",        1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd4, 16'h0004, 1'b1);
        // Hold when rd_en drops.
        step("hold_rd3",   1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 16'h0003, 1'b1);
        step("hold",       1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd4, 16'h0003, 1'b0);
        step("hold2",      1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd2, 16'h0003, 1'b0);
        // Simultaneous read/write to different addresses.
        step("simul",      1'b0, 1'b1, 3'd5, 16'hBEEF, 1'b1, 3'd2, 16'h0002, 1'b1);
        step("rd5",        1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 16'hBEEF, 1'b1);
        // Same-address collision.
        step("wr6",        1'b0, 1'b1, 3'd6, 16'h1111, 1'b0, 3'd0, 16'hBEEF, 1'b0);
        step("collide",    1'b0, 1'b1, 3'd6, 16'h2222, 1'b1, 3'd6, COLLIDE_EXP, 1'b1);
        step("rd6",        1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd6, 16'h2222, 1'b1);
        // Address extremes.
        step("wr0",        1'b0, 1'b1, 3'd0, 16'hA5A5, 1'b0, 3'd0, 16'h2222, 1'b0);
        step("wr7",        1'b0, 1'b1, 3'd7, 16'h1234, 1'b1, 3'd0, 16'hA5A5, 1'b1);
        step("rd7",        1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd7, 16'h1234, 1'b1);
        step("rd0",        1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd0, 16'hA5A5, 1'b1);
        // Reset mid-operation drops the write and the read.
        step("rst_mid",    1'b1, 1'b1, 3'd7, 16'h00AA, 1'b1, 3'd6, 16'h0000, 1'b0);
        step("post_rd7",   1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd7, 16'h0000, 1'b1);
        step("post_rd6",   1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd6, 16'h0000, 1'b1);
        step("post_rd5",   1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 16'h0000, 1'b1);
        // Memory still usable after reset.
        step("post_wr3",   1'b0, 1'b1, 3'd3, 16'h5A5A, 1'b0, 3'd0, 16'h0000, 1'b0);
        step("post_rd3",   1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 16'h5A5A, 1'b1);

        // ---------------- report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_data_mem_alt

// File: doc/data_mem_alt.md
Name: data_mem_alt

Overview:
- Simple dual-port register-file data memory: one write port and one read port, both on the same clock.
- Synchronous write; registered read with 1-cycle latency.
- Used as a small scratch/frame-line store in the frame-buffer datapath; contents are clearable by reset.
- Depth is 2**ADDR_WIDTH words of DATA_WIDTH bits.

Parameters:
- DATA_WIDTH, 8, bits per word (bench uses 16).
- ADDR_WIDTH, 8, address bits; DEPTH = 2**ADDR_WIDTH (bench uses 3, so 8 words).

Ports:
- clk  input  1  system clock; all activity on rising edge.
- reset  input  1  synchronous, active-high reset.
- wr_en  input  1  write enable, active-high.
- rd_en  input  1  read enable, active-high.
- wr_addr  input  ADDR_WIDTH  write address.
- rd_addr  input  ADDR_WIDTH  read address.
- wr_data  input  DATA_WIDTH  write data.
- rd_data  output  DATA_WIDTH  registered read data.
- rd_valid  output  1  high for the cycle rd_data was loaded by a read; may be left unconnected.

Behaviour:
- Reset is synchronous and active-high and has priority over wr_en and rd_en.
- While reset=1 at a rising edge:
  - every memory word is cleared to 0;
  - rd_data is cleared to 0;
  - rd_valid is cleared to 0;
  - writes and reads that cycle are ignored.
- Write: on a rising edge with reset=0 and wr_en=1, mem[wr_addr] <= wr_data. The new value is visible to reads issued from the next edge onward.
- Read: on a rising edge with reset=0 and rd_en=1, rd_data <= mem[rd_addr] and rd_valid <= 1. Latency is 1 cycle from the sampled address to the output.
- With rd_en=0, rd_data holds its last value and rd_valid <= 0.
- Read and write are independent and may occur in the same cycle to different addresses with no interaction.
- Same-address read during write (rd_addr == wr_addr, both enables high): rd_data returns the OLD stored word (read-first). The optional feature below overrides this.
- Addresses are full-range; no out-of-range case exists. There is no wrap logic beyond natural ADDR_WIDTH modulo.
- X/undriven enables are not required to be handled.
- There are no other state machines and no handshake beyond the enables.

Optional Feature:
- Macro: DATA_MEM_ALT_WR_BYPASS_EN.
- Defined: a same-address simultaneous read and write returns wr_data on rd_data (write-first forwarding).
- Not defined: read-first behaviour as stated above. The comparator/mux logic is absent.

Decomposition:
- Package data_mem_alt_pkg holds:
  - default DATA_WIDTH and ADDR_WIDTH constants;
  - a localparam-style DEPTH helper;
  - a word typedef sized by the default DATA_WIDTH.
- No sub-module: the array, write process and read register stay in one module.

Test Plan (DATA_WIDTH=16, ADDR_WIDTH=3):
- Reset: preload mem[1]=16'h0001, assert reset 1 cycle, then read addr 1 -> rd_data=16'h0000, rd_valid=0 during reset and 1 on the read.
- Write then read: write 16'h0002@2, 16'h0003@3, 16'h0004@4; then read addrs 2,3,4 on consecutive cycles -> rd_data = 0002, 0003, 0004, each 1 cycle after its address, rd_valid=1.
- Hold: read addr 3 (0003), then drop rd_en with rd_addr changed to 4 -> rd_data stays 0003, rd_valid=0.
- Simultaneous, different addresses: write 16'hBEEF@5 while reading addr 2 -> rd_data=0002; the next read of addr 5 -> BEEF.
- Same-address collision: mem[6]=16'h1111; write 16'h2222@6 while reading addr 6 -> rd_data=1111 without the macro, 2222 with DATA_MEM_ALT_WR_BYPASS_EN; the following read gives 2222 in both builds.
- Mid-operation reset: reset asserted in the same cycle as a write of 16'h00AA@7 with rd_en=1 -> write dropped, rd_data=0; the later read of addr 7 -> 16'h0000.
